// File: rtl/apb_master.sv
// APB requester: turns a one-cycle command strobe into a SETUP/ACCESS
// transfer on one of two slaves, with a bounded PREADY wait.
module apb_master #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic       PCLK,
   input  logic       PRESETn,
   input  logic       req,
   input  logic       wr,
   input  logic [7:0] addr,
   input  logic [7:0] wdata,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [7:0] rdata,
   output logic       PSEL1,
   output logic       PSEL2,
   output logic       PENABLE,
   output logic       PWRITE,
   output logic [7:0] PADDR,
   output logic [7:0] PWDATA,
   input  logic [7:0] PRDATA1,
   input  logic [7:0] PRDATA2,
   input  logic       PREADY1,
   input  logic       PREADY2
);

   localparam logic [7:0] TO = 8'(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_ACCESS
   } state_e;

   state_e     state_q, state_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       err_q, err_d;
   logic [7:0] rdata_q, rdata_d;
   logic       psel1_q, psel1_d;
   logic       psel2_q, psel2_d;
   logic       penable_q, penable_d;
   logic       pwrite_q, pwrite_d;
   logic [7:0] paddr_q, paddr_d;
   logic [7:0] pwdata_q, pwdata_d;
   logic [7:0] wcnt_q, wcnt_d;

   logic       sel_ready;
   logic [7:0] sel_rdata;
   logic [7:0] wcnt_inc;

   // Only the selected slave's response is ever looked at.
   assign sel_ready = psel2_q ? PREADY2 : PREADY1;
   assign sel_rdata = psel2_q ? PRDATA2 : PRDATA1;
   assign wcnt_inc  = wcnt_q + 8'd1;

   always_comb begin
      state_d   = state_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      rdata_d   = rdata_q;
      psel1_d   = psel1_q;
      psel2_d   = psel2_q;
      penable_d = penable_q;
      pwrite_d  = pwrite_q;
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
      wcnt_d    = wcnt_q;

      unique case (state_q)
         S_IDLE: begin
            psel1_d   = 1'b0;
            psel2_d   = 1'b0;
            penable_d = 1'b0;
            busy_d    = 1'b0;
            if (req) begin
               pwrite_d = wr;
               paddr_d  = addr;
               pwdata_d = wdata;
               psel1_d  = ~addr[7];
               psel2_d  = addr[7];
               busy_d   = 1'b1;
               state_d  = S_SETUP;
            end
         end
         S_SETUP: begin
            penable_d = 1'b1;
            wcnt_d    = 8'd0;
            state_d   = S_ACCESS;
         end
         S_ACCESS: begin
            if (sel_ready) begin
               psel1_d   = 1'b0;
               psel2_d   = 1'b0;
               penable_d = 1'b0;
               busy_d    = 1'b0;
               done_d    = 1'b1;
               if (!pwrite_q) begin
                  rdata_d = sel_rdata;
               end
               state_d = S_IDLE;
            end else begin
               wcnt_d = wcnt_inc;
               if (wcnt_inc == TO) begin
                  psel1_d   = 1'b0;
                  psel2_d   = 1'b0;
                  penable_d = 1'b0;
                  busy_d    = 1'b0;
                  done_d    = 1'b1;
                  err_d     = 1'b1;
                  state_d   = S_IDLE;
               end
            end
         end
         default: begin
            psel1_d   = 1'b0;
            psel2_d   = 1'b0;
            penable_d = 1'b0;
            busy_d    = 1'b0;
            state_d   = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q   <= S_IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         rdata_q   <= 8'h00;
         psel1_q   <= 1'b0;
         psel2_q   <= 1'b0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         paddr_q   <= 8'h00;
         pwdata_q  <= 8'h00;
         wcnt_q    <= 8'h00;
      end else begin
         state_q   <= state_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
         psel1_q   <= psel1_d;
         psel2_q   <= psel2_d;
         penable_q <= penable_d;
         pwrite_q  <= pwrite_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
         wcnt_q    <= wcnt_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign err     = err_q;
   assign rdata   = rdata_q;
   assign PSEL1   = psel1_q;
   assign PSEL2   = psel2_q;
   assign PENABLE = penable_q;
   assign PWRITE  = pwrite_q;
   assign PADDR   = paddr_q;
   assign PWDATA  = pwdata_q;

endmodule

// File: doc/apb_master.md
# apb_master

APB requester that sits directly upstream of the APB slaves, including the 64-byte register-file slave. It turns a simple single-cycle command strobe from the local controller into a full APB SETUP/ACCESS transfer. It decodes one of two slave selects from the address, waits on the selected slave's PREADY with a bounded timeout, and returns read data with a completion pulse.

## Interface
Parameters:
- TIMEOUT, 16: max ACCESS cycles with PREADY low before abort (range 1..255).

Ports:
- PCLK  in  1  APB clock; all state changes on its rising edge.
- PRESETn  in  1  asynchronous active-low reset.
- req  in  1  command strobe; sampled only in IDLE.
- wr  in  1  1 = write, 0 = read; sampled with req.
- addr  in  8  target address; addr[7] selects the slave (0 = slave 1, 1 = slave 2).
- wdata  in  8  write data; sampled with req.
- busy  out  1  high in SETUP and ACCESS.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid only with done; 1 = timeout abort.
- rdata  out  8  last successful read data; held until the next successful read.
- PSEL1, PSEL2  out  1  slave selects, one-hot or both 0.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  8  APB address; carries the full latched addr, with slave-local decoding left to the slave.
- PWDATA  out  8  APB write data.
- PRDATA1, PRDATA2  in  8  read data from slave 1 and slave 2.
- PREADY1, PREADY2  in  1  ready from slave 1 and slave 2.

## Operation
- States: IDLE, SETUP, ACCESS. All outputs are registered.
- IDLE with req=1:
  - latch wr, addr and wdata into PWRITE, PADDR and PWDATA;
  - assert PSEL1 if addr[7]=0, else PSEL2;
  - hold PENABLE=0 and go to SETUP.
- IDLE with req=0: stay in IDLE; PSELx=0 and PENABLE=0.
- SETUP: lasts exactly one cycle. Then set PENABLE=1, clear the wait counter and go to ACCESS.
- ACCESS, selected PREADYx=1 at the edge:
  - clear PSELx and PENABLE;
  - pulse done=1 with err=0;
  - if PWRITE=0, load rdata from the selected PRDATAx;
  - go to IDLE.
- ACCESS, selected PREADYx=0:
  - increment the 8-bit wait counter;
  - when the counter reaches TIMEOUT, clear PSELx and PENABLE, pulse done=1 with err=1, leave rdata unchanged and go to IDLE.
- The PREADY and PRDATA of the unselected slave are ignored at all times.
- PADDR, PWDATA and PWRITE are stable from SETUP through the end of ACCESS. After completion they hold their last value until the next accepted req.
- req while busy=1 is ignored; it is neither queued nor does it alter the transfer in progress.
- Reset values: state IDLE; busy, done, err, PSEL1, PSEL2, PENABLE, PWRITE = 0; PADDR, PWDATA, rdata = 8'h00; wait counter 0.
- Reset asserted mid-transfer: everything returns to reset values immediately, and no done pulse is produced.

## Timing
- Edge E0: req sampled high in IDLE. SETUP phase runs from E0 to E1 with PSELx=1 and PENABLE=0.
- Edge E1: PENABLE=1. ACCESS begins.
- Zero-wait slave: PREADYx=1 is sampled at E2. done=1 during E2..E3, and rdata is valid from E2 onward. Latency from req to done is 2 cycles.
- N wait states: done is asserted at edge E2+N.
- Timeout: done and err are asserted at edge E1+TIMEOUT when PREADYx stays low throughout.
- The next req is accepted no earlier than the edge after the done edge, because state is IDLE during the done cycle. Minimum issue interval is 3 cycles.
- The slaves drive PREADY combinationally from PSEL and PENABLE. This block samples PREADY only on clock edges while in ACCESS and must not combinationally loop it back to any output.

## Test plan
- Write to slave 1: req with wr=1, addr=8'h05, wdata=8'hA5 at E0; slave PREADY1=1 in ACCESS. Required: PSEL1=1 and PENABLE=0 in SETUP, PENABLE=1 in ACCESS, done=1 and err=0 at E2, PSEL2 never high. A following read of 8'h05 returns rdata=8'hA5.
- Read from slave 2 with 3 wait states: addr=8'h83, PRDATA2=8'h3C, PREADY2 held low 3 cycles. Required: PADDR=8'h83 stable throughout, done at E5, rdata=8'h3C, PSEL1=0 throughout.
- Timeout with TIMEOUT=4: PREADY1 tied 0. Required: done=1 and err=1 at E5, rdata unchanged from its prior value, PSEL1 and PENABLE=0 after the abort.
- Back-to-back: req held high continuously with zero-wait slaves. Required: a transfer starts every 3 cycles. req pulses during busy do not start extra transfers.
- Reset mid-ACCESS: drop PRESETn while PENABLE=1. Required: PSELx, PENABLE, busy and done go to 0 immediately without waiting for a clock edge, and no done pulse follows release.
- Unselected-slave isolation: PREADY2=1 with PRDATA2=8'hFF while reading slave 1 with PREADY1 low for 2 cycles. Required: no early completion, and rdata equals PRDATA1.
